// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with parallel Gray load, terminal-count
// flag, wrap pulse and optional saturation. Both count outputs come straight from registers.
module gray_counter_param #(
  parameter int          WIDTH    = 8,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned INIT_BIN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] INIT_VAL  = WIDTH'(INIT_BIN);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_VAL ^ (INIT_VAL >> 1);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gry;
  logic             wrap_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gry_d;
  logic             wrap_d;
  logic [WIDTH-1:0] step_val;
  logic             terminal;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray value is derived from the same next-binary value, so both registers move together.
  always_comb begin
    terminal = up_dn ? (bin == '1) : (bin == '0);
    step_val = up_dn ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
    bin_d    = bin;
    gry_d    = gry;
    wrap_d   = 1'b0;
    if (load) begin
      bin_d = gray_to_bin(load_gray);
      gry_d = load_gray;
    end else if (enable && !(SATURATE && terminal)) begin
      bin_d  = step_val;
      gry_d  = step_val ^ (step_val >> 1);
      wrap_d = terminal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin    <= INIT_VAL;
      gry    <= INIT_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin    <= bin_d;
      gry    <= gry_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin;
  assign gray_out = gry;
  assign wrap     = wrap_q;
  assign tc       = terminal;

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param: three instances (8-bit wrap, 4-bit
// saturating, 6-bit wrap with nonzero reset value) share one stimulus stream.
module tb_gray_counter_param;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       up_dn;
  logic       load;
  logic [7:0] load_gray;

  logic [7:0] gray_a, bin_a;
  logic       tc_a, wrap_a;
  logic [3:0] gray_b, bin_b;
  logic       tc_b, wrap_b;
  logic [5:0] gray_c, bin_c;
  logic       tc_c, wrap_c;

  typedef struct {
    int bin;
    bit wrap;
  } mstate_t;

  typedef struct {
    mstate_t a, b, c;
    bit      ud;
    bit      flip_a, flip_b, flip_c;
    int      prev_ga, prev_gb, prev_gc;
  } exp_t;

  exp_t    exp_q[$];
  mstate_t m_a, m_b, m_c;
  bit      m_valid = 0;
  int      n_checks = 0;
  int      n_fail = 0;
  int      plan_g[4] = '{1, 3, 2, 6};

  gray_counter_param #(.WIDTH(8), .SATURATE(1'b0), .INIT_BIN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .load(load),
    .load_gray(load_gray), .gray_out(gray_a), .bin_out(bin_a), .tc(tc_a), .wrap(wrap_a));

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b1), .INIT_BIN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .load(load),
    .load_gray(load_gray[3:0]), .gray_out(gray_b), .bin_out(bin_b), .tc(tc_b), .wrap(wrap_b));

  gray_counter_param #(.WIDTH(6), .SATURATE(1'b0), .INIT_BIN(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .load(load),
    .load_gray(load_gray[5:0]), .gray_out(gray_c), .bin_out(bin_c), .tc(tc_c), .wrap(wrap_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray to binary as the XOR of all right shifts of the Gray word.
  function automatic int g2b(input int g, input int w);
    int b = 0;
    for (int s = 0; s < w; s++) b ^= (g >> s);
    return b & ((1 << w) - 1);
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic bit model_tc(input int b, input bit ud, input int w);
    return ud ? (b == (1 << w) - 1) : (b == 0);
  endfunction

  function automatic mstate_t model_next(input mstate_t cur, input int w, input bit sat,
                                         input int init, input bit rn, input bit ld,
                                         input bit en, input bit ud, input int lg);
    int      maxv = (1 << w) - 1;
    bit      term;
    mstate_t n;
    n      = cur;
    n.wrap = 0;
    term   = model_tc(cur.bin, ud, w);
    if (!rn) n.bin = init;
    else if (ld) n.bin = g2b(lg & maxv, w);
    else if (en && !(sat && term)) begin
      n.bin  = (ud ? cur.bin + 1 : cur.bin - 1) & maxv;
      n.wrap = term;
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rn, input bit ld, input bit en, input bit ud, input logic [7:0] lg);
    exp_t e;
    rst_n     = rn;
    load      = ld;
    enable    = en;
    up_dn     = ud;
    load_gray = lg;
    if (m_valid) begin
      #1;
      checkOutput("tc_pre_a", 32'(tc_a), 32'(model_tc(m_a.bin, ud, 8)));
      checkOutput("tc_pre_b", 32'(tc_b), 32'(model_tc(m_b.bin, ud, 4)));
      checkOutput("tc_pre_c", 32'(tc_c), 32'(model_tc(m_c.bin, ud, 6)));
    end
    e.ud      = ud;
    e.flip_a  = m_valid && rn && !ld && en;
    e.flip_b  = m_valid && rn && !ld && en && !model_tc(m_b.bin, ud, 4);
    e.flip_c  = m_valid && rn && !ld && en;
    e.prev_ga = int'(gray_a);
    e.prev_gb = int'(gray_b);
    e.prev_gc = int'(gray_c);
    e.a = model_next(m_a, 8, 1'b0, 0, rn, ld, en, ud, int'(lg));
    e.b = model_next(m_b, 4, 1'b1, 0, rn, ld, en, ud, int'(lg));
    e.c = model_next(m_c, 6, 1'b0, 5, rn, ld, en, ud, int'(lg));
    m_a = e.a;
    m_b = e.b;
    m_c = e.c;
    if (!rn) m_valid = 1;
    exp_q.push_back(e);
  endtask

  task automatic sampleAndCheck();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    checkOutput("bin_a",  32'(bin_a),  32'(e.a.bin));
    checkOutput("gray_a", 32'(gray_a), 32'(b2g(e.a.bin)));
    checkOutput("wrap_a", 32'(wrap_a), 32'(e.a.wrap));
    checkOutput("tc_a",   32'(tc_a),   32'(model_tc(e.a.bin, e.ud, 8)));
    checkOutput("bin_b",  32'(bin_b),  32'(e.b.bin));
    checkOutput("gray_b", 32'(gray_b), 32'(b2g(e.b.bin)));
    checkOutput("wrap_b", 32'(wrap_b), 32'(e.b.wrap));
    checkOutput("tc_b",   32'(tc_b),   32'(model_tc(e.b.bin, e.ud, 4)));
    checkOutput("bin_c",  32'(bin_c),  32'(e.c.bin));
    checkOutput("gray_c", 32'(gray_c), 32'(b2g(e.c.bin)));
    checkOutput("wrap_c", 32'(wrap_c), 32'(e.c.wrap));
    checkOutput("tc_c",   32'(tc_c),   32'(model_tc(e.c.bin, e.ud, 6)));
    if (e.flip_a) checkOutput("flip_a", 32'($countones(gray_a ^ e.prev_ga[7:0])), 32'd1);
    if (e.flip_b) checkOutput("flip_b", 32'($countones(gray_b ^ e.prev_gb[3:0])), 32'd1);
    if (e.flip_c) checkOutput("flip_c", 32'($countones(gray_c ^ e.prev_gc[5:0])), 32'd1);
  endtask

  task automatic step(input bit rn, input bit ld, input bit en, input bit ud, input logic [7:0] lg);
    applyStimulus(rn, ld, en, ud, lg);
    sampleAndCheck();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_gray = '0;
    @(negedge clk);

    // Reset then count up
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    checkOutput("plan_reset_gray_a", 32'(gray_a), 32'h00);
    checkOutput("plan_reset_bin_c",  32'(bin_c),  32'h05);
    checkOutput("plan_reset_gray_c", 32'(gray_c), 32'h07);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 1, 8'h00);
      checkOutput("plan_up_gray_a", 32'(gray_a), 32'(plan_g[i]));
      checkOutput("plan_up_bin_a",  32'(bin_a),  32'(i + 1));
      checkOutput("plan_up_wrap_a", 32'(wrap_a), 32'd0);
    end

    // Up-wrap
    step(1, 1, 0, 1, 8'h80);
    checkOutput("plan_load_bin_a", 32'(bin_a), 32'hFF);
    checkOutput("plan_tc_up_a",    32'(tc_a),  32'd1);
    step(1, 0, 1, 1, 8'h00);
    checkOutput("plan_upwrap_bin_a",  32'(bin_a),  32'h00);
    checkOutput("plan_upwrap_gray_a", 32'(gray_a), 32'h00);
    checkOutput("plan_upwrap_wrap_a", 32'(wrap_a), 32'd1);
    step(1, 0, 0, 1, 8'h00);
    checkOutput("plan_wrap_clear_a", 32'(wrap_a), 32'd0);

    // Down-wrap
    step(0, 0, 0, 0, 8'h00);
    checkOutput("plan_tc_dn_a", 32'(tc_a), 32'd1);
    step(1, 0, 1, 0, 8'h00);
    checkOutput("plan_dnwrap_bin_a",  32'(bin_a),  32'hFF);
    checkOutput("plan_dnwrap_gray_a", 32'(gray_a), 32'h80);
    checkOutput("plan_dnwrap_wrap_a", 32'(wrap_a), 32'd1);
    step(1, 0, 1, 0, 8'h00);
    checkOutput("plan_dn2_bin_a",  32'(bin_a),  32'hFE);
    checkOutput("plan_dn2_gray_a", 32'(gray_a), 32'h81);

    // Load and priority
    step(1, 1, 1, 1, 8'hC0);
    checkOutput("plan_loadpri_bin_a",  32'(bin_a),  32'h80);
    checkOutput("plan_loadpri_gray_a", 32'(gray_a), 32'hC0);
    step(1, 1, 1, 1, 8'h2D);
    step(0, 1, 1, 1, 8'hC0);
    checkOutput("plan_rstpri_bin_a",  32'(bin_a),  32'h00);
    checkOutput("plan_rstpri_bin_c",  32'(bin_c),  32'h05);
    checkOutput("plan_rstpri_wrap_a", 32'(wrap_a), 32'd0);

    // Saturation on the 4-bit instance
    for (int i = 0; i < 17; i++) step(1, 0, 1, 1, 8'h00);
    checkOutput("plan_sat_bin_b",  32'(bin_b),  32'hF);
    checkOutput("plan_sat_gray_b", 32'(gray_b), 32'h8);
    checkOutput("plan_sat_wrap_b", 32'(wrap_b), 32'd0);
    checkOutput("plan_sat_tc_b",   32'(tc_b),   32'd1);
    step(1, 0, 0, 0, 8'h00);
    checkOutput("plan_sat_tcdn_b", 32'(tc_b), 32'd0);
    step(1, 0, 1, 0, 8'h00);
    checkOutput("plan_sat_dn_bin_b",  32'(bin_b),  32'hE);
    checkOutput("plan_sat_dn_gray_b", 32'(gray_b), 32'h9);

    // Random walk with occasional loads
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 99) == 0)
        step(1, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom()));
      else
        step(1, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
